// File: rtl/stimulus_sequencer_pkg.sv
// Shared definitions for the stimulus sequencer.
// Holds the controller state encoding and the sequence-mode constants
// used by the top level and by the testbench.
package stimulus_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_ALL    = 2'b01;
  localparam logic [1:0] MODE_LOOP   = 2'b10;
  localparam logic [1:0] MODE_REPEAT = 2'b11;

endpackage

// File: rtl/stim_wrap_counter.sv
// Modulo-N up-counter with clear, load and enable.
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset, count returns to 0
//   clear_i      synchronous clear to 0 (highest priority)
//   load_i       synchronous load of loadValue_i
//   loadValue_i  value taken on load_i
//   enable_i     advance by one, wrapping from MODULUS-1 to 0
//   count_o      current count
//   wrap_o       high while count_o sits at MODULUS-1
module stim_wrap_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadValue_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign wrap_o  = (count_q == WIDTH'(MODULUS - 1));
  assign count_o = count_q;

  // Next-count selection: clear beats load, load beats enable.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = loadValue_i;
    end else if (enable_i) begin
      count_d = wrap_o ? '0 : count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stimulus_sequencer.sv
// Stimulus sequencer: walks a multi-frame stimulus ROM, issuing one read
// per cycle while the downstream side is ready, with selectable sequence
// modes, programmable inter-frame gaps, frame markers and abort.
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   start           launch pulse, only honoured in IDLE
//   abort           stop request, honoured in RUN/GAP
//   mode            00 single, 01 all once, 10 loop all, 11 repeat one
//   frame_init      first frame to play
//   gap             idle cycles inserted between frames
//   ready           downstream accepts a word this cycle
//   rom_rd_address  in-frame offset
//   frame_sel       current frame
//   rd_en           word issued this cycle
//   sof / eof       rd_en at first / last offset of a frame
//   busy            sequencer is in RUN or GAP
//   done            one-cycle completion or abort pulse
//   frame_count     frames completed since start, saturating
module stimulus_sequencer
  import stimulus_sequencer_pkg::*;
#(
  parameter int DEPTH        = 257,
  parameter int ADDRESSWIDTH = 9,
  parameter int NFRAMES      = 4,
  parameter int FRAMEWIDTH   = 2,
  parameter int GAPWIDTH     = 8,
  parameter int CNTWIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [1:0]              mode,
  input  logic [FRAMEWIDTH-1:0]   frame_init,
  input  logic [GAPWIDTH-1:0]     gap,
  input  logic                    ready,
  output logic [ADDRESSWIDTH-1:0] rom_rd_address,
  output logic [FRAMEWIDTH-1:0]   frame_sel,
  output logic                    rd_en,
  output logic                    sof,
  output logic                    eof,
  output logic                    busy,
  output logic                    done,
  output logic [CNTWIDTH-1:0]     frame_count
);

  state_e                state_q;
  logic [1:0]            mode_q;
  logic [FRAMEWIDTH-1:0] frameInit_q;
  logic [GAPWIDTH-1:0]   gap_q;
  logic [GAPWIDTH-1:0]   gapCnt_q;
  logic [CNTWIDTH-1:0]   frameCount_q;
  logic [CNTWIDTH-1:0]   frameCount_d;

  logic                  launch;
  logic                  offsetWrap;
  logic                  frameWrap;
  logic                  advanceFrame;
  logic                  lastFrame;
  logic [FRAMEWIDTH-1:0] nextFrame;

  assign launch       = (state_q == ST_IDLE) & start;
  // abort suppresses the issue in the same cycle so no word slips out.
  assign rd_en        = (state_q == ST_RUN) & ready & ~abort;
  assign eof          = rd_en & offsetWrap;
  assign sof          = rd_en & (rom_rd_address == '0);
  assign busy         = (state_q == ST_RUN) | (state_q == ST_GAP);
  assign done         = (state_q == ST_DONE);
  assign frame_count  = frameCount_q;
  assign advanceFrame = eof & ((mode_q == MODE_ALL) | (mode_q == MODE_LOOP));
  assign nextFrame    = frameWrap ? '0 : frame_sel + FRAMEWIDTH'(1);
  assign frameCount_d = (&frameCount_q) ? frameCount_q : frameCount_q + CNTWIDTH'(1);

  // In all-once mode the run is over when the next frame would bring us
  // back to the frame we started on; loop and repeat never finish.
  always_comb begin
    lastFrame = 1'b0;
    case (mode_q)
      MODE_SINGLE: lastFrame = 1'b1;
      MODE_ALL:    lastFrame = (nextFrame == frameInit_q);
      default:     lastFrame = 1'b0;
    endcase
  end

  // In-frame offset: restarts at 0 on launch, advances on every issued word.
  stim_wrap_counter #(
    .WIDTH   (ADDRESSWIDTH),
    .MODULUS (DEPTH)
  ) u_offset (
    .clk_i       (clk),
    .rst_ni      (rst),
    .clear_i     (launch),
    .load_i      (1'b0),
    .loadValue_i ('0),
    .enable_i    (rd_en),
    .count_o     (rom_rd_address),
    .wrap_o      (offsetWrap)
  );

  // Frame select: loaded from frame_init on launch, stepped at end of frame
  // only in the modes that walk through frames.
  stim_wrap_counter #(
    .WIDTH   (FRAMEWIDTH),
    .MODULUS (NFRAMES)
  ) u_frame (
    .clk_i       (clk),
    .rst_ni      (rst),
    .clear_i     (1'b0),
    .load_i      (launch),
    .loadValue_i (frame_init),
    .enable_i    (advanceFrame),
    .count_o     (frame_sel),
    .wrap_o      (frameWrap)
  );

  // Control FSM with the configuration latch, gap countdown and
  // completed-frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= '0;
      frameInit_q  <= '0;
      gap_q        <= '0;
      gapCnt_q     <= '0;
      frameCount_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q       <= mode;
            frameInit_q  <= frame_init;
            gap_q        <= gap;
            frameCount_q <= '0;
            state_q      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_DONE;
          end else if (eof) begin
            frameCount_q <= frameCount_d;
            if (lastFrame) begin
              state_q <= ST_DONE;
            end else if (gap_q != '0) begin
              gapCnt_q <= gap_q;
              state_q  <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (abort) begin
            state_q <= ST_DONE;
          end else if (gapCnt_q <= GAPWIDTH'(1)) begin
            gapCnt_q <= '0;
            state_q  <= ST_RUN;
          end else begin
            gapCnt_q <= gapCnt_q - GAPWIDTH'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stimulus_sequencer.sv
// Directed testbench for stimulus_sequencer with DEPTH=4, NFRAMES=3.
module tb_stimulus_sequencer;
  import stimulus_sequencer_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int NF    = 3;
  localparam int FW    = 2;
  localparam int GW    = 8;
  localparam int CW    = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [FW-1:0] frame_init;
  logic [GW-1:0] gap;
  logic          ready;
  logic [AW-1:0] rom_rd_address;
  logic [FW-1:0] frame_sel;
  logic          rd_en;
  logic          sof;
  logic          eof;
  logic          busy;
  logic          done;
  logic [CW-1:0] frame_count;

  int checkCount;
  int failCount;

  stimulus_sequencer #(
    .DEPTH        (DEPTH),
    .ADDRESSWIDTH (AW),
    .NFRAMES      (NF),
    .FRAMEWIDTH   (FW),
    .GAPWIDTH     (GW),
    .CNTWIDTH     (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .mode           (mode),
    .frame_init     (frame_init),
    .gap            (gap),
    .ready          (ready),
    .rom_rd_address (rom_rd_address),
    .frame_sel      (frame_sel),
    .rd_en          (rd_en),
    .sof            (sof),
    .eof            (eof),
    .busy           (busy),
    .done           (done),
    .frame_count    (frame_count)
  );

  // 10-unit clock; inputs change on the falling edge, outputs sampled 1 later.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One cycle: drive inputs at the falling edge and settle before sampling.
  task automatic applyStimulus(input logic s, input logic a, input logic r);
    @(negedge clk);
    start = s;
    abort = a;
    ready = r;
    #1;
  endtask

  // Expect an issued word at the given offset and frame.
  task automatic checkWord(input string tag, input int addr, input int fsel);
    checkOutput({tag, " rd_en"}, int'(rd_en), 1);
    checkOutput({tag, " addr"}, int'(rom_rd_address), addr);
    checkOutput({tag, " fsel"}, int'(frame_sel), fsel);
    checkOutput({tag, " sof"}, int'(sof), (addr == 0) ? 1 : 0);
    checkOutput({tag, " eof"}, int'(eof), (addr == DEPTH - 1) ? 1 : 0);
    checkOutput({tag, " busy"}, int'(busy), 1);
  endtask

  // Expect the done pulse with the given final counters.
  task automatic checkDone(input string tag, input int fcount);
    checkOutput({tag, " done"}, int'(done), 1);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " rd_en"}, int'(rd_en), 0);
    checkOutput({tag, " fcount"}, int'(frame_count), fcount);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " addr"}, int'(rom_rd_address), 0);
    checkOutput({tag, " fsel"}, int'(frame_sel), 0);
    checkOutput({tag, " rd_en"}, int'(rd_en), 0);
    checkOutput({tag, " sof"}, int'(sof), 0);
    checkOutput({tag, " eof"}, int'(eof), 0);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " done"}, int'(done), 0);
    checkOutput({tag, " fcount"}, int'(frame_count), 0);
  endtask

  initial begin
    int order [3];
    checkCount = 0;
    failCount  = 0;
    rst        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    mode       = MODE_SINGLE;
    frame_init = '0;
    gap        = '0;
    ready      = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Test 1: single frame, frame 1, ready held high.
    mode       = MODE_SINGLE;
    frame_init = 2'd1;
    gap        = 8'd0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t1 idle rd_en", int'(rd_en), 0);
    checkOutput("t1 idle busy", int'(busy), 0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkWord("t1 word", i, 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkDone("t1", 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1 post done", int'(done), 0);
    checkOutput("t1 post rd_en", int'(rd_en), 0);

    // Test 2: backpressure for two cycles at offset 2.
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkWord("t2 word", i, 1);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t2 stall rd_en", int'(rd_en), 0);
      checkOutput("t2 stall addr", int'(rom_rd_address), 2);
      checkOutput("t2 stall busy", int'(busy), 1);
    end
    for (int i = 2; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkWord("t2 word", i, 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkDone("t2", 1);

    // Test 3: all frames once from frame 2 with a gap of 3.
    applyStimulus(1'b0, 1'b0, 1'b1);
    mode       = MODE_ALL;
    frame_init = 2'd2;
    gap        = 8'd3;
    order[0]   = 2;
    order[1]   = 0;
    order[2]   = 1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkWord("t3 word", i, order[f]);
      end
      if (f < 2) begin
        for (int g = 0; g < 3; g++) begin
          applyStimulus(1'b0, 1'b0, 1'b1);
          checkOutput("t3 gap rd_en", int'(rd_en), 0);
          checkOutput("t3 gap busy", int'(busy), 1);
          checkOutput("t3 gap fcount", int'(frame_count), f + 1);
        end
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkDone("t3", 3);

    // Test 4: loop mode without gaps, abort in frame 2 at offset 1.
    applyStimulus(1'b0, 1'b0, 1'b1);
    mode       = MODE_LOOP;
    frame_init = 2'd0;
    gap        = 8'd0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkWord("t4 word", i, f);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkWord("t4 f2 word", 0, 2);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t4 abort rd_en", int'(rd_en), 0);
    checkOutput("t4 abort addr", int'(rom_rd_address), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkDone("t4", 2);
    checkOutput("t4 held addr", int'(rom_rd_address), 1);
    checkOutput("t4 held fsel", int'(frame_sel), 2);

    // Test 5: repeat mode, ignored restart, then asynchronous reset.
    applyStimulus(1'b0, 1'b0, 1'b1);
    mode       = MODE_REPEAT;
    frame_init = 2'd2;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkWord("t5 word", i, 2);
    end
    frame_init = 2'd0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkWord("t5 restart ignored", 2, 2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkWord("t5 word", 3, 2);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkWord("t5 repeat", i, 2);
    end
    checkOutput("t5 fcount", int'(frame_count), 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("t5 reset");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t5 no done", int'(done), 0);
    rst        = 1'b1;
    frame_init = 2'd1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkWord("t5 fresh", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
